// File: rtl/csr_counter_bank.sv
// Performance-counter bank: cycle, instret and N_EVT event counters with per-counter
// inhibit, sticky overflow and XLEN-half software writes.

module csr_counter_cell #(
  parameter int CW   = 64,
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            inc,
  input  logic            wr,
  input  logic            wr_hi,
  input  logic [XLEN-1:0] wr_data,
  output logic [CW-1:0]   cnt,
  output logic            ovf
);
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (wr) begin
      // software write wins over a same-cycle increment and clears the sticky flag
      if (wr_hi) cnt[CW-1:XLEN] <= wr_data;
      else       cnt[XLEN-1:0]  <= wr_data;
      ovf <= 1'b0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
      if (&cnt) ovf <= 1'b1;
    end
  end
endmodule

module csr_counter_bank #(
  parameter  int CW    = 64,
  parameter  int XLEN  = 32,
  parameter  int N_EVT = 4,
  localparam int N_CNT = N_EVT + 2,
  localparam int IW    = $clog2(N_CNT)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             retire,
  input  logic             stall,
  input  logic             flush,
  input  logic [N_EVT-1:0] evt,
  input  logic             inhibit_we,
  input  logic [N_CNT-1:0] inhibit_wdata,
  output logic [N_CNT-1:0] inhibit,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic             wr_hi,
  input  logic [XLEN-1:0]  wr_data,
  input  logic [IW-1:0]    rd_idx,
  input  logic             rd_hi,
  output logic [XLEN-1:0]  rd_data,
  output logic [N_CNT-1:0] ovf
);
  logic                       armed;
  logic [N_CNT-1:0]           cond, inc, wr;
  logic [N_CNT-1:0][CW-1:0]   cnt;

  // armed holds off instret/event counting for the first edge after reset
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      armed   <= 1'b0;
      inhibit <= '0;
    end else begin
      armed <= 1'b1;
      if (inhibit_we) inhibit <= inhibit_wdata;
    end
  end

  assign cond = {evt & {N_EVT{armed}}, armed & retire & ~stall & ~flush, 1'b1};
  assign inc  = cond & ~inhibit;

  for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
    // out-of-range indices never match, so such writes fall away
    assign wr[g] = wr_en && (wr_idx == IW'(g));
    csr_counter_cell #(.CW(CW), .XLEN(XLEN)) u_cell (
      .CLK     (CLK),
      .RSTn    (RSTn),
      .inc     (inc[g]),
      .wr      (wr[g]),
      .wr_hi   (wr_hi),
      .wr_data (wr_data),
      .cnt     (cnt[g]),
      .ovf     (ovf[g])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_CNT; i++)
      if (rd_idx == IW'(i)) rd_data = rd_hi ? cnt[i][CW-1:XLEN] : cnt[i][XLEN-1:0];
  end
endmodule

// File: tb/tb_csr_counter_bank.sv
// Bench for csr_counter_bank: directed vector table, reset corner sequences and
// randomized traffic checked against a counter-array reference model.

module tb_csr_counter_bank;
  localparam int CW = 64, XLEN = 32, N_EVT = 4, N_CNT = 6, IW = 3;

  logic             CLK, RSTn;
  logic             retire, stall, flush;
  logic [N_EVT-1:0] evt;
  logic             inhibit_we;
  logic [N_CNT-1:0] inhibit_wdata, inhibit, ovf;
  logic             wr_en, wr_hi, rd_hi;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic [XLEN-1:0]  wr_data, rd_data;

  csr_counter_bank #(.CW(CW), .XLEN(XLEN), .N_EVT(N_EVT)) dut (
    .CLK(CLK), .RSTn(RSTn), .retire(retire), .stall(stall), .flush(flush), .evt(evt),
    .inhibit_we(inhibit_we), .inhibit_wdata(inhibit_wdata), .inhibit(inhibit),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_hi(wr_hi), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_hi(rd_hi), .rd_data(rd_data), .ovf(ovf)
  );

  initial CLK = 1'b0;
  always #50 CLK = ~CLK;

  int total = 0, bad = 0;

  // reference model: plain counter array
  logic [CW-1:0]    m_cnt [N_CNT];
  logic [N_CNT-1:0] m_ovf, m_inh;
  bit               m_armed;

  task automatic model_reset();
    for (int i = 0; i < N_CNT; i++) m_cnt[i] = '0;
    m_ovf = '0; m_inh = '0; m_armed = 0;
  endtask

  task automatic model_edge();
    bit ev;
    for (int i = 0; i < N_CNT; i++) begin
      if (i == 0)      ev = 1;
      else if (i == 1) ev = m_armed && retire && !stall && !flush;
      else             ev = m_armed && evt[i-2];
      if (wr_en && int'(wr_idx) == i) begin
        if (wr_hi) m_cnt[i] = {wr_data, m_cnt[i][31:0]};
        else       m_cnt[i] = {m_cnt[i][63:32], wr_data};
        m_ovf[i] = 0;
      end else if (ev && !m_inh[i]) begin
        if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf[i] = 1;
        m_cnt[i] = m_cnt[i] + 64'd1;
      end
    end
    if (inhibit_we) m_inh = inhibit_wdata;
    m_armed = 1;
  endtask

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] e;
    for (int i = 0; i < 8; i++)
      for (int h = 0; h < 2; h++) begin
        rd_idx = IW'(i); rd_hi = h[0];
        #1;
        e = '0;
        if (i < N_CNT) e = h ? {32'd0, m_cnt[i][63:32]} : {32'd0, m_cnt[i][31:0]};
        cmp($sformatf("rd[%0d].%0d", i, h), {32'd0, rd_data}, e);
      end
    cmp("ovf", {58'd0, ovf}, {58'd0, m_ovf});
    cmp("inhibit", {58'd0, inhibit}, {58'd0, m_inh});
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all();
  endtask

  task automatic idle_inputs();
    retire = 0; stall = 0; flush = 0; evt = '0; wr_en = 0; wr_idx = '0; wr_hi = 0;
    wr_data = '0; inhibit_we = 0; inhibit_wdata = '0;
  endtask

  task automatic rd_const(string name, int idx, bit hi, logic [31:0] exp);
    rd_idx = IW'(idx); rd_hi = hi;
    #1;
    cmp(name, {32'd0, rd_data}, {32'd0, exp});
  endtask

  // reset pulse away from any clock edge
  task automatic mid_reset();
    #5 RSTn = 0;
    model_reset();
    #1;
    check_all();
    @(negedge CLK);
    RSTn = 1;
  endtask

  typedef struct {
    logic             retire, stall, flush;
    logic [N_EVT-1:0] evt;
    logic             wr_en;
    logic [IW-1:0]    wr_idx;
    logic             wr_hi;
    logic [XLEN-1:0]  wr_data;
    logic             inh_we;
    logic [N_CNT-1:0] inh_wdata;
    logic [IW-1:0]    ci;
    logic             ch;
    logic [XLEN-1:0]  exp;
    logic [N_CNT-1:0] exp_ovf;
  } vec_t;

  vec_t tbl [24];

  initial begin
    // rows: edge n (1-based) after reset release; c0 = n until frozen after row 19
    tbl[0]  = '{1,0,0,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd1,0,32'd0,        6'h00};
    tbl[1]  = '{1,0,0,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd1,0,32'd1,        6'h00};
    tbl[2]  = '{1,0,0,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd1,0,32'd2,        6'h00};
    tbl[3]  = '{1,0,0,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd1,0,32'd3,        6'h00};
    tbl[4]  = '{1,0,0,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd0,0,32'd5,        6'h00};
    tbl[5]  = '{1,1,0,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd1,0,32'd4,        6'h00};
    tbl[6]  = '{1,1,0,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd1,0,32'd4,        6'h00};
    tbl[7]  = '{1,1,0,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd1,0,32'd4,        6'h00};
    tbl[8]  = '{1,0,1,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd1,0,32'd4,        6'h00};
    tbl[9]  = '{1,0,1,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd0,0,32'd10,       6'h00};
    tbl[10] = '{0,0,0,4'h0, 1,3'd2,0,32'hFFFF_FFFF, 0,6'h00, 3'd2,0,32'hFFFF_FFFF, 6'h00};
    tbl[11] = '{0,0,0,4'h1, 0,3'd0,0,32'h0,        0,6'h00, 3'd2,1,32'd1,        6'h00};
    tbl[12] = '{0,0,0,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd2,0,32'd0,        6'h00};
    tbl[13] = '{0,0,0,4'h0, 1,3'd2,1,32'hFFFF_FFFF, 0,6'h00, 3'd2,1,32'hFFFF_FFFF, 6'h00};
    tbl[14] = '{0,0,0,4'h0, 1,3'd2,0,32'hFFFF_FFFF, 0,6'h00, 3'd2,0,32'hFFFF_FFFF, 6'h00};
    tbl[15] = '{0,0,0,4'h1, 0,3'd0,0,32'h0,        0,6'h00, 3'd2,1,32'd0,        6'h04};
    tbl[16] = '{0,0,0,4'h0, 1,3'd2,0,32'h5,        0,6'h00, 3'd2,0,32'd5,        6'h00};
    tbl[17] = '{1,0,0,4'h0, 1,3'd1,0,32'h10,       0,6'h00, 3'd1,0,32'h10,       6'h00};
    tbl[18] = '{1,0,0,4'h0, 0,3'd0,0,32'h0,        1,6'h01, 3'd1,0,32'h11,       6'h00};
    tbl[19] = '{1,0,0,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd0,0,32'd19,       6'h00};
    tbl[20] = '{1,0,0,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd1,0,32'h13,       6'h00};
    tbl[21] = '{1,0,0,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd0,0,32'd19,       6'h00};
    tbl[22] = '{1,0,0,4'h0, 1,3'd7,0,32'hDEAD,     0,6'h00, 3'd7,0,32'd0,        6'h00};
    tbl[23] = '{1,0,0,4'h0, 0,3'd0,0,32'h0,        0,6'h00, 3'd1,0,32'h16,       6'h00};

    RSTn = 0; rd_idx = '0; rd_hi = 0;
    idle_inputs();
    model_reset();
    #2;
    check_all();
    @(negedge CLK);
    RSTn = 1;

    for (int r = 0; r < 24; r++) begin
      retire = tbl[r].retire; stall = tbl[r].stall; flush = tbl[r].flush; evt = tbl[r].evt;
      wr_en = tbl[r].wr_en; wr_idx = tbl[r].wr_idx; wr_hi = tbl[r].wr_hi;
      wr_data = tbl[r].wr_data; inhibit_we = tbl[r].inh_we; inhibit_wdata = tbl[r].inh_wdata;
      tick();
      rd_const($sformatf("row%0d", r), int'(tbl[r].ci), tbl[r].ch, tbl[r].exp);
      cmp($sformatf("row%0d.ovf", r), {58'd0, ovf}, {58'd0, tbl[r].exp_ovf});
    end

    // reset mid-count, then instret misses only the first edge after release
    idle_inputs();
    mid_reset();
    rd_const("rst.c0", 0, 0, 32'd0);
    rd_const("rst.c2", 2, 1, 32'd0);
    retire = 1;
    tick();
    rd_const("warm1.c0", 0, 0, 32'd1);
    rd_const("warm1.c1", 1, 0, 32'd0);
    tick();
    rd_const("warm2.c0", 0, 0, 32'd2);
    rd_const("warm2.c1", 1, 0, 32'd1);

    for (int n = 0; n < 450; n++) begin
      if (n % 150 == 75) mid_reset();
      retire = 1'($urandom);
      stall  = ($urandom % 4 == 0);
      flush  = ($urandom % 6 == 0);
      evt    = N_EVT'($urandom);
      wr_en  = ($urandom % 4 == 0);
      wr_idx = IW'($urandom);
      wr_hi  = 1'($urandom);
      case ($urandom % 3)
        0:       wr_data = 32'hFFFF_FFFF;
        1:       wr_data = 32'hFFFF_FFFE;
        default: wr_data = $urandom;
      endcase
      inhibit_we    = ($urandom % 12 == 0);
      inhibit_wdata = N_CNT'($urandom) & N_CNT'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
